// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph set (active-high a..g), digit count and scan-decoder FSM states.
// Used by both the display encoder and the scan decoder so the two agree on every glyph.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } seg7_state_e;

  // Encoder-side lookup: nibble to active-high segment pattern.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decode: active-high a..g pattern to hex nibble, zero latency, no backpressure.
// Unrecognised patterns return nibble 0 with err set.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive 7-seg scan monitor rebuilding the 8-digit frame; capture lands SETTLE_CYC edges after pins settle.
// No backpressure (observer only); define SEG7_DEC_DP_EN to capture per-digit decimal points into dp_o.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  disp_seg_i,
  input  logic [7:0]  disp_an_i,
  output logic [31:0] frame_o,
  output logic        frame_valid_o,
  output logic [7:0]  digit_err_o,
  output logic [7:0]  dp_o,
  output logic        timeout_o
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

  logic [7:0]    seg_q;
  logic [7:0]    an_q;
  logic [7:0]    an_lock;
  logic [7:0]    an_sel;
  seg7_state_e   state;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_inc;
  logic [TW-1:0] tmo_cnt;
  logic          an_valid;
  logic          an_same;
  logic          restart;
  logic          cont;
  logic          capture;
  logic          frame_done;
  logic [2:0]    dig_idx;
  logic [6:0]    seg_pat;
  logic [3:0]    dec_nib;
  logic          dec_err;
  logic [7:0]    seen;
  logic [7:0]    seen_nx;
  logic [3:0]    shadow_nib [SEG7_DIGITS];
  logic [7:0]    shadow_err;
  logic [31:0]   frame_nx;
  logic [7:0]    err_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_q <= 8'hFF;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= disp_seg_i;
      an_q  <= disp_an_i;
    end
  end

  // Blanking (no anode low) and ghosting (several low) both count as invalid.
  assign an_sel   = ~an_q;
  assign an_valid = (an_sel != 8'h00) && ((an_sel & (an_sel - 8'h01)) == 8'h00);
  assign an_same  = (an_q == an_lock);

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < SEG7_DIGITS; i++) begin
      if (an_sel[i]) dig_idx = 3'(i);
    end
  end

  assign seg_pat = ~seg_q[6:0];

  seg7_glyph_decode u_glyph (
    .pattern (seg_pat),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  // A fresh valid anode starts a run at count 1, so SETTLE_CYC==1 captures on that same edge.
  assign restart    = an_valid && ((state == S_IDLE) || !an_same);
  assign cont       = an_valid && (state == S_SETTLE) && an_same;
  assign settle_inc = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
  assign capture    = (restart && (SETTLE_CYC == 1)) || (cont && (settle_inc == SETTLE_MAX));
  assign seen_nx    = seen | (8'h01 << dig_idx);
  assign frame_done = capture && (seen_nx == 8'hFF);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      an_lock    <= 8'hFF;
    end else begin
      case (state)
        S_IDLE: begin
          if (an_valid) begin
            an_lock    <= an_q;
            settle_cnt <= SW'(1);
            state      <= capture ? S_HOLD : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!an_valid) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
          end else if (!an_same) begin
            an_lock    <= an_q;
            settle_cnt <= SW'(1);
            state      <= capture ? S_HOLD : S_SETTLE;
          end else begin
            settle_cnt <= settle_inc;
            if (capture) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!an_valid) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
          end else if (!an_same) begin
            an_lock    <= an_q;
            settle_cnt <= SW'(1);
            state      <= capture ? S_HOLD : S_SETTLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  // The completing digit is still in flight, so merge it into the published frame directly.
  always_comb begin
    frame_nx = '0;
    for (int i = 0; i < SEG7_DIGITS; i++) begin
      frame_nx[4*i +: 4] = (dig_idx == 3'(i)) ? dec_nib : shadow_nib[i];
    end
    err_nx          = shadow_err;
    err_nx[dig_idx] = dec_err;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen          <= '0;
      shadow_err    <= '0;
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
      digit_err_o   <= '0;
      for (int i = 0; i < SEG7_DIGITS; i++) shadow_nib[i] <= 4'h0;
    end else begin
      frame_valid_o <= frame_done;
      if (capture) begin
        shadow_nib[dig_idx] <= dec_nib;
        shadow_err[dig_idx] <= dec_err;
        seen                <= frame_done ? 8'h00 : seen_nx;
      end
      if (frame_done) begin
        frame_o     <= frame_nx;
        digit_err_o <= err_nx;
      end
    end
  end

`ifdef SEG7_DEC_DP_EN
  logic [7:0] shadow_dp;
  logic [7:0] dp_nx;

  always_comb begin
    dp_nx          = shadow_dp;
    dp_nx[dig_idx] = ~seg_q[7];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_dp <= '0;
      dp_o      <= '0;
    end else begin
      if (capture) shadow_dp[dig_idx] <= ~seg_q[7];
      if (frame_done) dp_o <= dp_nx;
    end
  end
`else
  logic dp_unused;
  assign dp_unused = seg_q[7];
  assign dp_o      = 8'h00;
`endif

  // A frame completing on the very edge the limit is reached takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (frame_done) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (tmo_cnt != TIMEOUT_MAX) begin
      tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_cnt + TW'(1) == TIMEOUT_MAX) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans plus randomized sweeps against a
// run-length reference model of the scan bus.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;
`ifdef SEG7_DEC_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  disp_seg_i = 8'hFF;
  logic [7:0]  disp_an_i = 8'hFF;
  logic [31:0] frame_o;
  logic        frame_valid_o;
  logic [7:0]  digit_err_o;
  logic [7:0]  dp_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .disp_seg_i    (disp_seg_i),
    .disp_an_i     (disp_an_i),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .digit_err_o   (digit_err_o),
    .dp_o          (dp_o),
    .timeout_o     (timeout_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a digit is captured when the registered anode has shown the same single
  // low bit for exactly SETTLE consecutive samples.
  logic [7:0]  m_an_q, m_seg_q, run_an;
  int          run_len;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_err_sh, m_dp_sh, m_seen;
  logic [31:0] m_frame;
  logic [7:0]  m_err, m_dp;
  int          m_tcnt;
  logic        m_timeout;
  int          m_pulses = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_an_q = 8'hFF; m_seg_q = 8'hFF; run_an = 8'hFF; run_len = 0;
      m_err_sh = 0; m_dp_sh = 0; m_seen = 0; m_frame = 0; m_err = 0; m_dp = 0;
      m_tcnt = 0; m_timeout = 0;
      for (int i = 0; i < 8; i++) m_nib[i] = 0;
    end else begin : model_step
      logic done;
      int k;
      logic [6:0] pat;
      logic [3:0] nib;
      logic bad;
      done = 1'b0;
      if ($countones(~m_an_q) != 1) run_len = 0;
      else if (run_len > 0 && m_an_q == run_an) run_len++;
      else begin run_an = m_an_q; run_len = 1; end
      if (run_len == SETTLE) begin
        k = 0;
        for (int i = 0; i < 8; i++) if (!m_an_q[i]) k = i;
        pat = ~m_seg_q[6:0]; nib = 0; bad = 1'b1;
        for (int j = 0; j < 16; j++) if (glyph_tab[j] == pat) begin nib = 4'(j); bad = 1'b0; end
        m_nib[k] = nib; m_err_sh[k] = bad; m_dp_sh[k] = DP_EN ? ~m_seg_q[7] : 1'b0;
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
          for (int i = 0; i < 8; i++) m_frame[4*i +: 4] = m_nib[i];
          m_err = m_err_sh; m_dp = m_dp_sh; m_seen = 0; m_pulses++; done = 1'b1;
        end
      end
      if (done) begin m_tcnt = 0; m_timeout = 1'b0; end
      else if (m_tcnt < TMO) begin m_tcnt++; if (m_tcnt == TMO) m_timeout = 1'b1; end
      m_an_q = disp_an_i; m_seg_q = disp_seg_i;
    end
  end

  int   cyc = 0, dut_pulses = 0, pulse_cyc = 0;
  logic to_at_pulse = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (frame_valid_o === 1'b1) begin dut_pulses++; pulse_cyc = cyc; to_at_pulse = timeout_o; end
  end

  function automatic logic [7:0] enc(input logic [3:0] nib, input logic dp);
    logic [6:0] g;
    g = glyph_tab[nib];
    return ~{dp, g};
  endfunction

  task automatic drive_digit(input int k, input logic [7:0] seg, input int dwell);
    disp_an_i = ~(8'h01 << k);
    disp_seg_i = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic sweep(input logic [31:0] val, input int dwell, input logic [7:0] dpm);
    for (int k = 0; k < 8; k++) drive_digit(k, enc(val[4*k +: 4], dpm[k]), dwell);
  endtask

  task automatic do_reset();
    rstn = 1'b0; disp_an_i = 8'hFF; disp_seg_i = 8'hFF;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk); #1;
    n_checks++; if (frame_o !== 32'h0) begin n_fail++; $display("FAIL reset_frame: got %h want 00000000", frame_o); end
    n_checks++; if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid_o); end
    n_checks++; if (digit_err_o !== 8'h0) begin n_fail++; $display("FAIL reset_err: got %h want 00", digit_err_o); end
    n_checks++; if (dp_o !== 8'h0) begin n_fail++; $display("FAIL reset_dp: got %h want 00", dp_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    rstn = 1'b1;
    repeat (2) @(negedge clk); #1;
    n_checks++; if (frame_valid_o !== 1'b0 || frame_o !== 32'h0) begin n_fail++; $display("FAIL post_reset_idle: got valid %b frame %h want 0/0", frame_valid_o, frame_o); end
  endtask

  task automatic test_basic_scan();
    int p0, mp0;
    do_reset();
    p0 = dut_pulses; mp0 = m_pulses;
    repeat (3) sweep(32'h12345678, 8, 8'h00);
    #1;
    n_checks++; if (frame_o !== 32'h12345678) begin n_fail++; $display("FAIL basic_frame: got %h want 12345678", frame_o); end
    n_checks++; if (digit_err_o !== 8'h00) begin n_fail++; $display("FAIL basic_err: got %h want 00", digit_err_o); end
    n_checks++; if (dut_pulses - p0 != 3) begin n_fail++; $display("FAIL basic_pulses: got %0d want 3", dut_pulses - p0); end
    n_checks++; if (m_pulses - mp0 != 3) begin n_fail++; $display("FAIL basic_model_pulses: got %0d want 3", m_pulses - mp0); end
    n_checks++; if (timeout_o !== m_timeout) begin n_fail++; $display("FAIL basic_timeout: got %b want %b", timeout_o, m_timeout); end
  endtask

  task automatic test_short_dwell();
    logic [31:0] val;
    int p0;
    val = $urandom;
    do_reset();
    p0 = dut_pulses;
    repeat (2) for (int k = 0; k < 8; k++) drive_digit(k, enc(val[4*k +: 4], 1'b0), (k == 2) ? 2 : 8);
    #1;
    n_checks++; if (dut_pulses - p0 != 0) begin n_fail++; $display("FAIL short_no_pulse: got %0d pulses want 0", dut_pulses - p0); end
    n_checks++; if (timeout_o !== m_timeout) begin n_fail++; $display("FAIL short_timeout: got %b want %b", timeout_o, m_timeout); end
    sweep(val, 8, 8'h00);
    #1;
    n_checks++; if (dut_pulses - p0 != 1) begin n_fail++; $display("FAIL short_restore_pulse: got %0d want 1", dut_pulses - p0); end
    n_checks++; if (frame_o !== val) begin n_fail++; $display("FAIL short_restore_frame: got %h want %h", frame_o, val); end
  endtask

  task automatic test_blank_digit();
    logic [31:0] val;
    int p0;
    val = 32'hDEADBEEF;
    do_reset();
    p0 = dut_pulses;
    repeat (2) for (int k = 0; k < 8; k++) drive_digit(k, (k == 3) ? 8'hFF : enc(val[4*k +: 4], 1'b0), 8);
    #1;
    n_checks++; if (frame_o !== 32'hDEAD0EEF) begin n_fail++; $display("FAIL blank_frame: got %h want DEAD0EEF", frame_o); end
    n_checks++; if (digit_err_o !== 8'h08) begin n_fail++; $display("FAIL blank_err: got %h want 08", digit_err_o); end
    n_checks++; if (dut_pulses - p0 != 2) begin n_fail++; $display("FAIL blank_pulses: got %0d want 2", dut_pulses - p0); end
  endtask

  task automatic test_multi_anode();
    logic [31:0] val;
    int p0;
    val = $urandom;
    do_reset();
    p0 = dut_pulses;
    for (int k = 0; k < 4; k++) drive_digit(k, enc(val[4*k +: 4], 1'b0), 8);
    disp_an_i = 8'hFC; disp_seg_i = enc(4'h8, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    n_checks++; if (dut_pulses - p0 != 0) begin n_fail++; $display("FAIL multi_no_pulse: got %0d want 0", dut_pulses - p0); end
    for (int k = 4; k < 8; k++) drive_digit(k, enc(val[4*k +: 4], 1'b0), 8);
    #1;
    n_checks++; if (dut_pulses - p0 != 1) begin n_fail++; $display("FAIL multi_pulse: got %0d want 1", dut_pulses - p0); end
    n_checks++; if (frame_o !== val || digit_err_o !== 8'h00) begin n_fail++; $display("FAIL multi_frame: got %h/%h want %h/00", frame_o, digit_err_o, val); end
    n_checks++; if (timeout_o !== m_timeout) begin n_fail++; $display("FAIL multi_timeout: got %b want %b", timeout_o, m_timeout); end
  endtask

  task automatic test_timeout();
    int p0, waited;
    do_reset();
    p0 = dut_pulses;
    sweep(32'hA5C30F96, 8, 8'h00);
    disp_an_i = 8'hFF; disp_seg_i = 8'hFF;
    #1;
    n_checks++; if (dut_pulses - p0 != 1) begin n_fail++; $display("FAIL tmo_pre_frame: got %0d pulses want 1", dut_pulses - p0); end
    waited = 0;
    while (timeout_o !== 1'b1 && waited < 200) begin @(negedge clk); #1; waited++; end
    n_checks++; if (cyc - pulse_cyc != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles want %0d", cyc - pulse_cyc, TMO); end
    repeat (100) @(negedge clk); #1;
    n_checks++; if (timeout_o !== 1'b1 || m_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b model %b want 1", timeout_o, m_timeout); end
    p0 = dut_pulses;
    sweep(32'h0F1E2D3C, 8, 8'h00);
    #1;
    n_checks++; if (dut_pulses - p0 != 1) begin n_fail++; $display("FAIL tmo_resume_pulse: got %0d want 1", dut_pulses - p0); end
    n_checks++; if (to_at_pulse !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_on_frame: got %b want 0", to_at_pulse); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_after_resume: got %b want 0", timeout_o); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] a, b;
    int p0;
    a = $urandom | 32'h1;
    b = $urandom;
    do_reset();
    sweep(a, 8, 8'h00);
    for (int k = 0; k < 5; k++) drive_digit(k, enc(b[4*k +: 4], 1'b0), 8);
    rstn = 1'b0; disp_an_i = 8'hFF;
    #1;
    n_checks++; if (frame_o !== 32'h0 || digit_err_o !== 8'h0 || dp_o !== 8'h0 || timeout_o !== 1'b0 || frame_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL midreset_clear: got frame %h err %h dp %h to %b v %b want all 0", frame_o, digit_err_o, dp_o, timeout_o, frame_valid_o); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    p0 = dut_pulses;
    for (int j = 0; j < 7; j++) drive_digit((j + 5) % 8, enc(b[4*((j+5)%8) +: 4], 1'b0), 8);
    #1;
    n_checks++; if (dut_pulses - p0 != 0 || frame_o !== 32'h0) begin n_fail++; $display("FAIL midreset_seven: got %0d pulses frame %h want 0/0", dut_pulses - p0, frame_o); end
    drive_digit(4, enc(b[19:16], 1'b0), 8);
    #1;
    n_checks++; if (dut_pulses - p0 != 1 || frame_o !== b) begin n_fail++; $display("FAIL midreset_eighth: got %0d pulses frame %h want 1/%h", dut_pulses - p0, frame_o, b); end
  endtask

  task automatic test_dp();
    logic [7:0] want;
    do_reset();
    sweep(32'h89ABCDEF, 8, 8'h01);
    #1;
    want = DP_EN ? 8'h01 : 8'h00;
    n_checks++; if (dp_o !== want) begin n_fail++; $display("FAIL dp_digit0: got %h want %h", dp_o, want); end
    n_checks++; if (frame_o !== 32'h89ABCDEF) begin n_fail++; $display("FAIL dp_frame: got %h want 89ABCDEF", frame_o); end
  endtask

  task automatic test_random();
    logic [31:0] val;
    logic [7:0]  dpm;
    int p0, mp0;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      val = $urandom; dpm = 8'($urandom);
      p0 = dut_pulses; mp0 = m_pulses;
      for (int k = 0; k < 8; k++) begin
        drive_digit(k, ($urandom_range(0, 7) == 0) ? 8'($urandom) : enc(val[4*k +: 4], dpm[k]),
                    $urandom_range(1, 10));
        if ($urandom_range(0, 5) == 0) begin
          disp_an_i = ($urandom_range(0, 1) == 0) ? 8'hFF : ~(8'h03 << $urandom_range(0, 6));
          repeat ($urandom_range(1, 5)) @(negedge clk);
        end
      end
      #1;
      n_checks++; if (frame_o !== m_frame) begin n_fail++; $display("FAIL rand_frame[%0d]: got %h want %h", s, frame_o, m_frame); end
      n_checks++; if (digit_err_o !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %h want %h", s, digit_err_o, m_err); end
      n_checks++; if (dp_o !== m_dp) begin n_fail++; $display("FAIL rand_dp[%0d]: got %h want %h", s, dp_o, m_dp); end
      n_checks++; if (timeout_o !== m_timeout) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %b want %b", s, timeout_o, m_timeout); end
      n_checks++; if (dut_pulses - p0 != m_pulses - mp0) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", s, dut_pulses - p0, m_pulses - mp0); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_blank_digit();
    test_multi_anode();
    test_timeout();
    test_reset_midframe();
    test_dp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
